cci_mpf_shim_vtp_tlb_server: RTL and testbench
==============================================

Name: cci_mpf_shim_vtp_tlb_server

Overview:
Direct-mapped 4KB-page TLB implementing the server end of the VTP TLB lookup/fill interface. It serves two independent lookup ports with fixed 2-cycle latency, reports hit (PA) or miss (echoed VA), and accepts fills from the page table walker. It sits between the VTP pipeline (client) and the walker (fill).

Parameters:
NUM_SETS_LOG2, 6, log2 of entry count; entry index = VA page idx[NUM_SETS_LOG2-1:0], tag = remaining upper bits.
VA_IDX_BITS, 36, 4KB VA page index width (42-6).
PA_IDX_BITS, 26, 4KB PA page index width (32-6).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
lookupPageVA0, lookupPageVA1  in  VA_IDX_BITS each  lookup VA page index, port 0/1
lookupEn0, lookupEn1  in  1 each  lookup request
lookupRdy0, lookupRdy1  out  1 each  port can accept request
lookupRspPagePA0, lookupRspPagePA1  out  PA_IDX_BITS each  translated PA page index
lookupValid0, lookupValid1  out  1 each  hit response
lookupMiss0, lookupMiss1  out  1 each  miss response
lookupMissVA0, lookupMissVA1  out  VA_IDX_BITS each  VA of missed lookup
fillEn  in  1  fill request
fillVA  in  VA_IDX_BITS  fill VA page index
fillPA  in  PA_IDX_BITS  fill PA page index
fillRdy  out  1  fill can be accepted

Behaviour:
- Storage: 2^NUM_SETS_LOG2 entries {valid, tag, PA}, held in RAM-style storage (no async clear); one write port, two read ports.
- FSM: INIT, RUN. reset_n low -> INIT, init counter=0, all pipeline valids cleared.
- INIT: write valid=0 to entry[counter] each cycle; counter increments; after writing entry 2^NUM_SETS_LOG2-1 -> RUN. INIT lasts exactly 2^NUM_SETS_LOG2 cycles after reset release.
- lookupRdy0/1 and fillRdy: 0 in INIT and in reset; 1 in RUN (no backpressure in RUN).
- Accept: lookup accepted in cycle T when lookupEnN && lookupRdyN. lookupEnN while Rdy=0 is ignored, no response.
- Pipeline: T: RAM address registered; T+1: entry read, tag/VA registered; T+2: compare, responses driven (registered outputs not required; combinational compare on T+2 stage regs permitted).
- Response at T+2, exactly one of: lookupValidN=1 with lookupRspPagePAN=entry PA (hit = valid && tag match); or lookupMissN=1 with lookupMissVAN=requested VA. Both 0 in cycles without a response. One response per accepted request; back-to-back requests give back-to-back responses.
- Ports 0 and 1 fully independent; same VA on both in the same cycle -> identical results.
- Fill: accepted in cycle F when fillEn && fillRdy; entry[fillVA index] <= {1, fillVA tag, fillPA} at end of F. Unconditional overwrite (direct-mapped eviction); same-VA refill overwrites PA.
- Fill/lookup ordering: lookup accepted in cycle F (same cycle as fill) sees pre-fill contents; lookups accepted at F+1 or later see the fill. No bypass into in-flight lookups.
- fillEn during INIT ignored (fillRdy=0).
- Reset values: all Rdy=0, lookupValidN=0, lookupMissN=0, lookupRspPagePAN=0, lookupMissVAN=0.
- Reset mid-operation: in-flight lookups dropped, no responses after reset release, table re-invalidated via INIT.

Optional Feature:
CCI_MPF_VTP_TLB_STATS_EN: when defined, adds outputs statHits (32b) and statMisses (32b). Each counts responses summed over both ports (+0/+1/+2 per cycle), saturating at 2^32-1, cleared by reset. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release -> lookupRdy0/1 and fillRdy stay 0 for exactly 64 cycles (NUM_SETS_LOG2=6), then 1; any lookupEn during INIT -> no response.
- Lookup VA 0x000000123 on port 0 after INIT -> cycle T+2: lookupMiss0=1, lookupMissVA0=0x000000123, lookupValid0=0.
- Fill VA 0x000000123 / PA 0x0000456, then lookup on both ports same cycle -> T+2: lookupValid0=lookupValid1=1, PA 0x0000456 on both.
- Fill VA 0x000000000 PA 0x1, then fill VA 0x000000040 PA 0x2 (same index) -> lookup 0x000000000 misses; lookup 0x000000040 hits PA 0x2.
- Fill VA 0x7 and lookup VA 0x7 in same cycle F -> miss; lookup at F+1 -> hit; with CCI_MPF_VTP_TLB_STATS_EN, statMisses=1 and statHits=1.
- Assert reset_n low during 4 back-to-back lookups -> outputs 0 immediately; no responses after release; prior fills gone (post-INIT lookup misses).

Source files
------------

// File: rtl/cci_mpf_shim_vtp_tlb_server_if.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_vtp_tlb_server_if
//
// Lookup/fill bus between the VTP pipeline and walker (master side) and the
// TLB server (slave side).
//
//   lookupPageVAn, lookupEnn   master -> slave   lookup request, port n (0/1)
//   lookupRdyn                 slave  -> master  port n can accept a request
//   lookupValidn, lookupRspPagePAn               hit response, translated PA
//   lookupMissn, lookupMissVAn                   miss response, echoed VA
//   fillEn, fillVA, fillPA     master -> slave   fill request from the walker
//   fillRdy                    slave  -> master  fill can be accepted
// ---------------------------------------------------------------------------
interface cci_mpf_shim_vtp_tlb_server_if #(
    parameter int unsigned VA_IDX_BITS = 36,
    parameter int unsigned PA_IDX_BITS = 26
);
    logic [VA_IDX_BITS-1:0] lookupPageVA0;
    logic [VA_IDX_BITS-1:0] lookupPageVA1;
    logic                   lookupEn0;
    logic                   lookupEn1;
    logic                   lookupRdy0;
    logic                   lookupRdy1;
    logic [PA_IDX_BITS-1:0] lookupRspPagePA0;
    logic [PA_IDX_BITS-1:0] lookupRspPagePA1;
    logic                   lookupValid0;
    logic                   lookupValid1;
    logic                   lookupMiss0;
    logic                   lookupMiss1;
    logic [VA_IDX_BITS-1:0] lookupMissVA0;
    logic [VA_IDX_BITS-1:0] lookupMissVA1;

    logic                   fillEn;
    logic [VA_IDX_BITS-1:0] fillVA;
    logic [PA_IDX_BITS-1:0] fillPA;
    logic                   fillRdy;

    modport master (
        output lookupPageVA0, lookupPageVA1, lookupEn0, lookupEn1,
        output fillEn, fillVA, fillPA,
        input  lookupRdy0, lookupRdy1, lookupRspPagePA0, lookupRspPagePA1,
        input  lookupValid0, lookupValid1, lookupMiss0, lookupMiss1,
        input  lookupMissVA0, lookupMissVA1, fillRdy
    );

    modport slave (
        input  lookupPageVA0, lookupPageVA1, lookupEn0, lookupEn1,
        input  fillEn, fillVA, fillPA,
        output lookupRdy0, lookupRdy1, lookupRspPagePA0, lookupRspPagePA1,
        output lookupValid0, lookupValid1, lookupMiss0, lookupMiss1,
        output lookupMissVA0, lookupMissVA1, fillRdy
    );
endinterface

// File: rtl/cci_mpf_shim_vtp_tlb_server.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_vtp_tlb_server
//
// Direct-mapped 4KB-page TLB. Serves two independent lookup ports with a
// fixed 2-cycle latency (hit -> PA, miss -> echoed VA) and accepts fills
// from the page table walker. After reset the table is invalidated one
// entry per cycle (INIT) before any request is accepted.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   tlb                    lookup/fill bus (slave modport)
//   statHits, statMisses   response counters, only with
//                          CCI_MPF_VTP_TLB_STATS_EN defined
//
// Optional feature macro: CCI_MPF_VTP_TLB_STATS_EN
// ---------------------------------------------------------------------------
module cci_mpf_shim_vtp_tlb_server #(
    parameter int unsigned NUM_SETS_LOG2 = 6,
    parameter int unsigned VA_IDX_BITS   = 36,
    parameter int unsigned PA_IDX_BITS   = 26
) (
    input  logic clk,
    input  logic reset_n,
    cci_mpf_shim_vtp_tlb_server_if.slave tlb
`ifdef CCI_MPF_VTP_TLB_STATS_EN
    ,
    output logic [31:0] statHits,
    output logic [31:0] statMisses
`endif
);
    localparam int unsigned NUM_SETS = 1 << NUM_SETS_LOG2;
    localparam int unsigned TAG_BITS = VA_IDX_BITS - NUM_SETS_LOG2;

    typedef logic [NUM_SETS_LOG2-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]      tag_t;
    typedef logic [VA_IDX_BITS-1:0]   va_t;
    typedef logic [PA_IDX_BITS-1:0]   pa_t;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e state_q;
    idx_t   initCnt_q;
    logic   rdy_q;

    // Per-port views of the bus
    logic [1:0] lookupEn;
    va_t        lookupVa [2];

    assign lookupEn    = {tlb.lookupEn1, tlb.lookupEn0};
    assign lookupVa[0] = tlb.lookupPageVA0;
    assign lookupVa[1] = tlb.lookupPageVA1;

    // ---------------------------------------------------------------------
    // Table storage: one write port shared by INIT and fills, two read ports
    // ---------------------------------------------------------------------
    logic tblValid [NUM_SETS];
    tag_t tblTag   [NUM_SETS];
    pa_t  tblPa    [NUM_SETS];

    logic wrEn;
    idx_t wrIdx;
    logic wrValid;
    tag_t wrTag;
    pa_t  wrPa;

    always_comb begin
        wrEn    = 1'b0;
        wrIdx   = initCnt_q;
        wrValid = 1'b0;
        wrTag   = '0;
        wrPa    = '0;
        if (state_q == StInit) begin
            wrEn = 1'b1;
        end else if (tlb.fillEn) begin
            wrEn    = 1'b1;
            wrIdx   = tlb.fillVA[NUM_SETS_LOG2-1:0];
            wrValid = 1'b1;
            wrTag   = tlb.fillVA[VA_IDX_BITS-1:NUM_SETS_LOG2];
            wrPa    = tlb.fillPA;
        end
    end

    // Synchronous read samples the table at the same edge a fill writes it,
    // so a lookup accepted alongside a fill sees the pre-fill entry.
    logic [1:0] rdValid_q;
    tag_t       rdTag_q [2];
    pa_t        rdPa_q  [2];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tblValid[wrIdx] <= wrValid;
            tblTag[wrIdx]   <= wrTag;
            tblPa[wrIdx]    <= wrPa;
        end
        for (int p = 0; p < 2; p++) begin
            rdValid_q[p] <= tblValid[lookupVa[p][NUM_SETS_LOG2-1:0]];
            rdTag_q[p]   <= tblTag[lookupVa[p][NUM_SETS_LOG2-1:0]];
            rdPa_q[p]    <= tblPa[lookupVa[p][NUM_SETS_LOG2-1:0]];
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM and lookup pipeline
    // ---------------------------------------------------------------------
    logic [1:0] s1Valid_q;
    va_t        s1Va_q [2];
    logic [1:0] s2Valid_q;
    va_t        s2Va_q [2];
    logic [1:0] s2EntValid_q;
    tag_t       s2EntTag_q [2];
    pa_t        s2EntPa_q  [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInit;
            initCnt_q    <= '0;
            rdy_q        <= 1'b0;
            s1Valid_q    <= '0;
            s2Valid_q    <= '0;
            s2EntValid_q <= '0;
            for (int p = 0; p < 2; p++) begin
                s1Va_q[p]     <= '0;
                s2Va_q[p]     <= '0;
                s2EntTag_q[p] <= '0;
                s2EntPa_q[p]  <= '0;
            end
        end else begin
            case (state_q)
                StInit: begin
                    initCnt_q <= initCnt_q + 1'b1;
                    if (initCnt_q == idx_t'(NUM_SETS - 1)) begin
                        state_q <= StRun;
                        rdy_q   <= 1'b1;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase

            for (int p = 0; p < 2; p++) begin
                s1Valid_q[p]    <= lookupEn[p] && rdy_q;
                s1Va_q[p]       <= lookupVa[p];
                s2Valid_q[p]    <= s1Valid_q[p];
                s2Va_q[p]       <= s1Va_q[p];
                s2EntValid_q[p] <= rdValid_q[p];
                s2EntTag_q[p]   <= rdTag_q[p];
                s2EntPa_q[p]    <= rdPa_q[p];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Tag compare and responses
    // ---------------------------------------------------------------------
    logic [1:0] rspHit;
    logic [1:0] rspMiss;
    pa_t        rspPa [2];
    va_t        rspVa [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rspHit[p]  = s2Valid_q[p] && s2EntValid_q[p] &&
                         (s2EntTag_q[p] == s2Va_q[p][VA_IDX_BITS-1:NUM_SETS_LOG2]);
            rspMiss[p] = s2Valid_q[p] && !rspHit[p];
            rspPa[p]   = rspHit[p]  ? s2EntPa_q[p] : '0;
            rspVa[p]   = rspMiss[p] ? s2Va_q[p]    : '0;
        end
    end

    assign tlb.lookupRdy0       = rdy_q;
    assign tlb.lookupRdy1       = rdy_q;
    assign tlb.fillRdy          = rdy_q;
    assign tlb.lookupValid0     = rspHit[0];
    assign tlb.lookupValid1     = rspHit[1];
    assign tlb.lookupMiss0      = rspMiss[0];
    assign tlb.lookupMiss1      = rspMiss[1];
    assign tlb.lookupRspPagePA0 = rspPa[0];
    assign tlb.lookupRspPagePA1 = rspPa[1];
    assign tlb.lookupMissVA0    = rspVa[0];
    assign tlb.lookupMissVA1    = rspVa[1];

`ifdef CCI_MPF_VTP_TLB_STATS_EN
    // ---------------------------------------------------------------------
    // Saturating response counters
    // ---------------------------------------------------------------------
    logic [31:0] statHits_q;
    logic [31:0] statMisses_q;

    function automatic logic [31:0] satAdd(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            statHits_q   <= '0;
            statMisses_q <= '0;
        end else begin
            statHits_q   <= satAdd(statHits_q, {1'b0, rspHit[0]} + {1'b0, rspHit[1]});
            statMisses_q <= satAdd(statMisses_q, {1'b0, rspMiss[0]} + {1'b0, rspMiss[1]});
        end
    end

    assign statHits   = statHits_q;
    assign statMisses = statMisses_q;
`endif
endmodule

// File: tb/tb_cci_mpf_shim_vtp_tlb_server.sv
module tb_cci_mpf_shim_vtp_tlb_server;
    localparam int unsigned VA_IDX_BITS = 36;
    localparam int unsigned PA_IDX_BITS = 26;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    cci_mpf_shim_vtp_tlb_server_if #(
        .VA_IDX_BITS(VA_IDX_BITS),
        .PA_IDX_BITS(PA_IDX_BITS)
    ) tlbIf ();

`ifdef CCI_MPF_VTP_TLB_STATS_EN
    logic [31:0] statHits;
    logic [31:0] statMisses;
    logic [31:0] hits0;
    logic [31:0] misses0;
`endif

    cci_mpf_shim_vtp_tlb_server #(
        .NUM_SETS_LOG2(6),
        .VA_IDX_BITS(VA_IDX_BITS),
        .PA_IDX_BITS(PA_IDX_BITS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tlb(tlbIf)
`ifdef CCI_MPF_VTP_TLB_STATS_EN
        ,
        .statHits(statHits),
        .statMisses(statMisses)
`endif
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        tlbIf.lookupEn0     = 1'b0;
        tlbIf.lookupEn1     = 1'b0;
        tlbIf.lookupPageVA0 = '0;
        tlbIf.lookupPageVA1 = '0;
        tlbIf.fillEn        = 1'b0;
        tlbIf.fillVA        = '0;
        tlbIf.fillPA        = '0;
    endtask

    task automatic checkNoRsp(input string tag);
        checkEq(tag, {60'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0,
                     tlbIf.lookupValid1, tlbIf.lookupMiss1}, 64'h0);
    endtask

    // Counts cycles until ready rises; any response or inconsistent ready
    // during the wait is an error.
    task automatic waitInit(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (!tlbIf.lookupRdy0 && n < 200) begin
            if (tlbIf.lookupValid0 || tlbIf.lookupMiss0 || tlbIf.lookupValid1 ||
                tlbIf.lookupMiss1 || tlbIf.lookupRdy1 || tlbIf.fillRdy)
                bad++;
            step();
            n++;
        end
        idleInputs();
        checkEq({tag, "_initLen"}, 64'(n), 64'd64);
        checkEq({tag, "_initQuiet"}, 64'(bad), 64'd0);
        checkEq({tag, "_rdyAll"}, {61'b0, tlbIf.lookupRdy0, tlbIf.lookupRdy1, tlbIf.fillRdy},
                64'h7);
    endtask

    initial begin
        idleInputs();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        step();
        step();

        // Reset state
        checkEq("rst_rdy", {61'b0, tlbIf.lookupRdy0, tlbIf.lookupRdy1, tlbIf.fillRdy}, 64'h0);
        checkNoRsp("rst_rsp");
        checkEq("rst_pa0", 64'(tlbIf.lookupRspPagePA0), 64'h0);
        checkEq("rst_va1", 64'(tlbIf.lookupMissVA1), 64'h0);
`ifdef CCI_MPF_VTP_TLB_STATS_EN
        checkEq("rst_stats", {statHits, statMisses}, 64'h0);
`endif

        // Requests held through INIT must be ignored
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h7;
        tlbIf.lookupEn1     = 1'b1;
        tlbIf.lookupPageVA1 = 36'h123;
        tlbIf.fillEn        = 1'b1;
        tlbIf.fillVA        = 36'h123;
        tlbIf.fillPA        = 26'h3FF;
        reset_n = 1'b1;
        waitInit("init1");
        step();
        checkNoRsp("init1_late1");
        step();
        checkNoRsp("init1_late2");

        // Cold miss on port 0 (INIT-time fill must not have landed)
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h123;
        step();
        idleInputs();
        step();
        checkEq("miss_flag", {62'b0, tlbIf.lookupMiss0, tlbIf.lookupValid0}, 64'h2);
        checkEq("miss_va", 64'(tlbIf.lookupMissVA0), 64'h123);
        checkEq("miss_p1idle", {62'b0, tlbIf.lookupMiss1, tlbIf.lookupValid1}, 64'h0);
        step();
        checkNoRsp("miss_single");

        // Fill then dual-port hit on the same VA
        tlbIf.fillEn = 1'b1;
        tlbIf.fillVA = 36'h123;
        tlbIf.fillPA = 26'h456;
        step();
        idleInputs();
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h123;
        tlbIf.lookupEn1     = 1'b1;
        tlbIf.lookupPageVA1 = 36'h123;
        step();
        idleInputs();
        step();
        checkEq("dual_flags", {60'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0,
                               tlbIf.lookupValid1, tlbIf.lookupMiss1}, 64'hA);
        checkEq("dual_pa0", 64'(tlbIf.lookupRspPagePA0), 64'h456);
        checkEq("dual_pa1", 64'(tlbIf.lookupRspPagePA1), 64'h456);
        step();

        // Conflict eviction: 0x0 and 0x40 share index 0
        tlbIf.fillEn = 1'b1;
        tlbIf.fillVA = 36'h0;
        tlbIf.fillPA = 26'h1;
        step();
        tlbIf.fillVA = 36'h40;
        tlbIf.fillPA = 26'h2;
        step();
        idleInputs();
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h0;
        tlbIf.lookupEn1     = 1'b1;
        tlbIf.lookupPageVA1 = 36'h40;
        step();
        idleInputs();
        step();
        checkEq("evict_flags", {60'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0,
                                tlbIf.lookupValid1, tlbIf.lookupMiss1}, 64'h6);
        checkEq("evict_va0", 64'(tlbIf.lookupMissVA0), 64'h0);
        checkEq("evict_pa1", 64'(tlbIf.lookupRspPagePA1), 64'h2);
        step();
        checkNoRsp("evict_quiet");

        // Fill/lookup ordering: same-cycle lookup sees old contents
`ifdef CCI_MPF_VTP_TLB_STATS_EN
        hits0   = statHits;
        misses0 = statMisses;
`endif
        tlbIf.fillEn        = 1'b1;
        tlbIf.fillVA        = 36'h7;
        tlbIf.fillPA        = 26'h2ABCDEF;
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h7;
        step();
        tlbIf.fillEn = 1'b0;
        step();
        idleInputs();
        checkEq("order_f_flags", {62'b0, tlbIf.lookupMiss0, tlbIf.lookupValid0}, 64'h2);
        checkEq("order_f_va", 64'(tlbIf.lookupMissVA0), 64'h7);
        step();
        checkEq("order_f1_flags", {62'b0, tlbIf.lookupMiss0, tlbIf.lookupValid0}, 64'h1);
        checkEq("order_f1_pa", 64'(tlbIf.lookupRspPagePA0), 64'h2ABCDEF);
        step();
        checkNoRsp("order_quiet");
`ifdef CCI_MPF_VTP_TLB_STATS_EN
        checkEq("stat_misses", 64'(statMisses - misses0), 64'd1);
        checkEq("stat_hits", 64'(statHits - hits0), 64'd1);
`endif

        // Top of VA/PA range, same index different tag on port 1
        tlbIf.fillEn = 1'b1;
        tlbIf.fillVA = 36'hFFFFFFFFF;
        tlbIf.fillPA = 26'h3FFFFFF;
        step();
        idleInputs();
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'hFFFFFFFFF;
        tlbIf.lookupEn1     = 1'b1;
        tlbIf.lookupPageVA1 = 36'h0FFFFFFFF;
        step();
        idleInputs();
        step();
        checkEq("max_flags", {60'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0,
                              tlbIf.lookupValid1, tlbIf.lookupMiss1}, 64'h9);
        checkEq("max_pa0", 64'(tlbIf.lookupRspPagePA0), 64'h3FFFFFF);
        checkEq("max_va1", 64'(tlbIf.lookupMissVA1), 64'h0FFFFFFFF);
        step();

        // Reset during a burst of four hitting lookups
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h123;
        step();
        step();
        checkEq("burst_hit1", {62'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0}, 64'h2);
        step();
        reset_n = 1'b0;
        #1;
        checkNoRsp("midrst_rsp");
        checkEq("midrst_pa0", 64'(tlbIf.lookupRspPagePA0), 64'h0);
        checkEq("midrst_rdy", {61'b0, tlbIf.lookupRdy0, tlbIf.lookupRdy1, tlbIf.fillRdy},
                64'h0);
`ifdef CCI_MPF_VTP_TLB_STATS_EN
        checkEq("midrst_stats", {statHits, statMisses}, 64'h0);
`endif
        idleInputs();
        step();
        step();
        reset_n = 1'b1;
        waitInit("init2");
        step();
        checkNoRsp("init2_late1");
        step();
        checkNoRsp("init2_late2");

        // Earlier fills must be gone
        tlbIf.lookupEn0     = 1'b1;
        tlbIf.lookupPageVA0 = 36'h123;
        tlbIf.lookupEn1     = 1'b1;
        tlbIf.lookupPageVA1 = 36'h7;
        step();
        idleInputs();
        step();
        checkEq("post_flags", {60'b0, tlbIf.lookupValid0, tlbIf.lookupMiss0,
                               tlbIf.lookupValid1, tlbIf.lookupMiss1}, 64'h5);
        checkEq("post_va0", 64'(tlbIf.lookupMissVA0), 64'h123);
        checkEq("post_va1", 64'(tlbIf.lookupMissVA1), 64'h7);
        step();
        checkNoRsp("post_quiet");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
